// File: rtl/uart_cpu_port_if.sv
// CPU-side bundle of the UART port: transmit request/data/busy and receive irq/data/ack.
// Latency: none (wires only).
// Backpressure: w_busy high means a w_req is dropped; irr is held until ack.
interface uart_cpu_port_if;
    logic       w_req;
    logic [7:0] w_data;
    logic       w_busy;
    logic       ack;
    logic       irr;
    logic [7:0] r_data;

    // CPU side drives requests and acks, observes status
    modport master (output w_req, w_data, ack, input w_busy, irr, r_data);
    // UART port side consumes requests and acks, reports status
    modport slave  (input w_req, w_data, ack, output w_busy, irr, r_data);
endinterface

// File: rtl/uart_cpu_port.sv
// 8N1 UART with a CPU special-register style port (w_req/w_busy out, irr/r_data/ack in).
// Latency: uart_tx falls 1 cycle after an accepted w_req; r_data/irr update 1 cycle after the stop sample.
// Backpressure: w_req while w_busy is dropped (no queue); a byte arriving while irr=1 overwrites r_data.
module uart_cpu_port #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    uart_cpu_port_if.slave cpu,
    output logic           uart_tx,
    input  logic           uart_rx
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cyc;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_q;
    logic          tx_bit_end;
    logic          tx_busy;

    assign tx_bit_end = (tx_cyc == CW'(CLKS_PER_BIT - 1));

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) tx_state <= T_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    // TX next state: each non-idle state holds for whole bit periods
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            T_IDLE:  if (cpu.w_req) tx_state_nxt = T_START;
            T_START: if (tx_bit_end) tx_state_nxt = T_DATA;
            T_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = T_STOP;
            T_STOP:  if (tx_bit_end) tx_state_nxt = T_IDLE;
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    // TX outputs: busy whenever a frame is in flight
    always_comb begin
        tx_busy = (tx_state != T_IDLE);
    end

    // TX datapath: counters, shift register and the registered line driver
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cyc <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_q   <= 1'b1;
        end else begin
            if (tx_state == T_IDLE || tx_bit_end) tx_cyc <= '0;
            else                                  tx_cyc <= tx_cyc + CW'(1);
            case (tx_state)
                T_IDLE: begin
                    tx_bit <= '0;
                    if (cpu.w_req) begin
                        tx_sh <= cpu.w_data;
                        tx_q  <= 1'b0;
                    end
                end
                T_START: if (tx_bit_end) tx_q <= tx_sh[0];
                T_DATA: begin
                    if (tx_bit_end) begin
                        tx_bit <= tx_bit + 3'd1;
                        tx_sh  <= tx_sh >> 1;
                        // after the 8th bit the line goes to the stop level
                        tx_q   <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
                    end
                end
                default: tx_q <= 1'b1;
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign cpu.w_busy = tx_busy;

    // ---------------- receiver ----------------
    rx_state_t     rx_state, rx_state_nxt;
    logic          rx_s1, rx_s2;
    logic [CW-1:0] rx_cyc;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_half, rx_full;
    logic          rx_done;
    logic [7:0]    r_data_q;
    logic          irr_q;

    assign rx_half = (rx_cyc == CW'(HALF));
    assign rx_full = (rx_cyc == CW'(CLKS_PER_BIT - 1));

    // two-flop synchronizer on the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    // RX next state: half-bit start check, then whole-bit spaced samples
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            R_IDLE:  if (!rx_s2) rx_state_nxt = R_START;
            R_START: if (rx_half) rx_state_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_full && rx_bit == 3'd7) rx_state_nxt = R_STOP;
            R_STOP:  if (rx_full) rx_state_nxt = R_IDLE;
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // RX outputs: a byte completes only on a good stop sample
    always_comb begin
        rx_done = (rx_state == R_STOP) && rx_full && rx_s2;
    end

    // RX datapath: sample counter and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cyc <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    rx_cyc <= '0;
                    rx_bit <= '0;
                end
                R_START: rx_cyc <= rx_half ? '0 : rx_cyc + CW'(1);
                R_DATA: begin
                    if (rx_full) begin
                        rx_cyc <= '0;
                        rx_bit <= rx_bit + 3'd1;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                    end else begin
                        rx_cyc <= rx_cyc + CW'(1);
                    end
                end
                default: rx_cyc <= rx_cyc + CW'(1);
            endcase
        end
    end

    // CPU receive registers: completion beats ack, overrun overwrites
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= 8'h00;
            irr_q    <= 1'b0;
        end else if (rx_done) begin
            r_data_q <= rx_sh;
            irr_q    <= 1'b1;
        end else if (cpu.ack) begin
            irr_q    <= 1'b0;
        end
    end

    assign cpu.r_data = r_data_q;
    assign cpu.irr    = irr_q;
endmodule

// File: doc/uart_cpu_port.md
UART_CPU_PORT -- requirements
Module: uart_cpu_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 w_req  input  1  CPU write request, single-cycle pulse from the execute stage.
REQ-005 w_data  input  8  byte to transmit, valid when w_req=1.
REQ-006 w_busy  output  1  transmitter busy; mirrors the CPU special-register w_busy.
REQ-007 ack  input  1  CPU acknowledge of received byte, single-cycle pulse.
REQ-008 irr  output  1  interrupt request: received byte pending.
REQ-009 r_data  output  8  last received byte; mirrors the CPU special-register r_data.
REQ-010 uart_tx  output  1  serial transmit line, idle high.
REQ-011 uart_rx  input  1  serial receive line, asynchronous, idle high.

Function
REQ-012 Frame format: 8N1, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 TX FSM states: T_IDLE, T_START, T_DATA, T_STOP; the bit counter is 3 bits and the cycle counter is $clog2(CLKS_PER_BIT) bits.
REQ-014 In T_IDLE, w_req=1 latches w_data into the shift register and enters T_START; in the next cycle, uart_tx=0 and w_busy=1.
REQ-015 w_req while w_busy=1 is ignored; the byte in flight is not disturbed and the request is not queued.
REQ-016 T_START lasts CLKS_PER_BIT cycles, then T_DATA shifts out 8 bits, then T_STOP drives 1 for CLKS_PER_BIT cycles, then the FSM returns to T_IDLE.
REQ-017 w_busy=1 exactly when TX state != T_IDLE, i.e. for 10*CLKS_PER_BIT cycles per accepted byte; a new w_req is accepted in the first cycle w_busy=0.
REQ-018 uart_tx is driven from a register (glitch-free) and is 1 in T_IDLE.
REQ-019 uart_rx passes through a 2-flop synchronizer before any use; the synchronizer adds 2 cycles of latency.
REQ-020 RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
REQ-021 R_IDLE: a synchronized 0 enters R_START and clears the cycle counter.
REQ-022 R_START: the line is sampled at cycle CLKS_PER_BIT/2 (integer division). If it reads 1, this is a false start and the FSM returns to R_IDLE; if it reads 0, the FSM enters R_DATA.
REQ-023 R_DATA: 8 samples are taken, each CLKS_PER_BIT cycles after the previous one (mid-bit), and shifted in LSB first.
REQ-024 R_STOP: the line is sampled CLKS_PER_BIT cycles after the last data sample, then the FSM returns to R_IDLE.
REQ-025 Stop sample = 1: on the next cycle, r_data is loaded and irr is set to 1.
REQ-026 Stop sample = 0 (framing error): the byte is discarded; r_data and irr are unchanged.
REQ-027 irr stays at 1 until ack=1; ack clears irr on the next cycle, and ack while irr=0 has no effect.
REQ-028 A byte that completes while irr=1 (overrun) overwrites r_data, and irr stays 1.
REQ-029 If a byte completes in the same cycle as ack, the completion wins: r_data gets the new byte and irr stays 1.
REQ-030 r_data is stable except in the single load cycle of REQ-025; the CPU may read it at any time.
REQ-031 TX and RX are fully independent; simultaneous TX and RX traffic, including loopback of uart_tx to uart_rx, has no interaction.

Reset
REQ-032 While rst=1: uart_tx=1, w_busy=0, irr=0, r_data=8'h00; both FSMs are in IDLE; all counters and shift registers are 0; both synchronizer flops are 1.
REQ-033 rst asserted mid-frame aborts both FSMs. From the next clock, uart_tx=1 and w_busy=0, and the partial RX byte is discarded.
REQ-034 In the first cycle after rst deasserts, w_req is accepted normally.

Verification (CLKS_PER_BIT=4)
REQ-035 TX byte: w_req with w_data=8'hA5 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles per bit; w_busy=1 for exactly 40 cycles.
REQ-036 Busy drop: a second w_req with 8'h3C during the 8'hA5 frame -> only the 8'hA5 frame appears; a w_req on the first cycle w_busy=0 starts a 8'h3C frame.
REQ-037 RX byte: drive a valid 8'h5A frame on uart_rx -> r_data=8'h5A and irr=1 one cycle after the stop sample; ack -> irr=0 next cycle, and r_data stays 8'h5A.
REQ-038 Errors: a 1-cycle low glitch on uart_rx -> no irr (false start). A frame for 8'h11 with stop bit 0 -> r_data and irr unchanged.
REQ-039 Overrun and race: receive 8'h01, then 8'h02 without ack -> r_data=8'h02, irr=1. Pulse ack in the completion cycle of 8'h03 -> r_data=8'h03, irr=1.
REQ-040 Reset mid-frame: assert rst at bit 4 of a TX frame and an RX frame -> uart_tx=1, w_busy=0, irr=0, r_data=8'h00; then a loopback of 8'hC3 -> received 8'hC3.
